// File: rtl/stopwatch.sv
// ---------------------------------------------------------------------------
// stopwatch -- elapsed-time peripheral on the nano6502 register bus.
//
// The CPU starts and stops a centisecond counter and reads it back through a
// snapshot register, so a 16-bit value is never torn across two 8-bit reads.
// A count wrap sets a sticky overflow flag, which can optionally drive an
// interrupt.
//
// Optional feature macro: STOPWATCH_IRQ_EN (adds register 06 irq_en and a
// registered irq_n_o; without it irq_n_o is tied high).
//
// Parameters:
//   CLK_FRE      system clock frequency in Hz
//   CS_DELAY     clock cycles per centisecond tick (2 .. 2^18-1)
// Ports:
//   clk_i        system clock, rising edge
//   rst_n_i      asynchronous active-low reset
//   R_W_n        bus direction, 1 = read, 0 = write
//   reg_addr_i   register select
//   data_i       write data
//   stopwatch_cs chip select, one clock per bus access
//   data_o       read data, combinational from reg_addr_i
//   irq_n_o      active-low interrupt request
// ---------------------------------------------------------------------------
module stopwatch #(
    parameter int CLK_FRE  = 25_175_000,
    parameter int CS_DELAY = CLK_FRE / 100
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       R_W_n,
    input  logic [2:0] reg_addr_i,
    input  logic [7:0] data_i,
    input  logic       stopwatch_cs,
    output logic [7:0] data_o,
    output logic       irq_n_o
);

    localparam logic [17:0] PRESC_MAX = 18'(CS_DELAY - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        RUNNING = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [17:0] prescaler_r;
    logic [17:0] prescaler_nxt_s;
    logic [15:0] count_r;
    logic [15:0] count_nxt_s;
    logic [15:0] count_inc_s;
    logic [15:0] snapshot_r;
    logic        ovf_r;
    logic        irq_en_s;
    logic [7:0]  rd_data_s;

    logic wr_s;
    logic start_s;
    logic stop_s;
    logic latch_s;
    logic clr_s;
    logic running_s;
    logic tick_s;
    logic wrap_s;

    // data_i bits are only partly consumed depending on configuration
    logic unused_s;
    assign unused_s = ^data_i;

    assign wr_s      = stopwatch_cs && !R_W_n;
    assign start_s   = wr_s && (reg_addr_i == 3'd1);
    assign stop_s    = wr_s && (reg_addr_i == 3'd2);
    assign latch_s   = wr_s && (reg_addr_i == 3'd3);
    assign clr_s     = wr_s && (reg_addr_i == 3'd0);
    assign running_s = (state_r == RUNNING);
    assign tick_s    = running_s && (prescaler_r == PRESC_MAX);
    assign wrap_s    = tick_s && (count_r == 16'hFFFF);
    // Post-edge count if no start occurs; used by stop so a same-edge tick is kept
    assign count_inc_s = tick_s ? (count_r + 16'd1) : count_r;

    // Next-state logic for the IDLE/RUNNING controller
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    state_nxt_s = RUNNING;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUNNING: begin
                if (start_s) begin
                    state_nxt_s = RUNNING;
                end else if (stop_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RUNNING;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Next prescaler and count: start restarts both, otherwise tick-driven
    always_comb begin
        prescaler_nxt_s = prescaler_r;
        count_nxt_s     = count_r;
        if (start_s) begin
            prescaler_nxt_s = 18'd0;
            count_nxt_s     = 16'd0;
        end else if (tick_s) begin
            prescaler_nxt_s = 18'd0;
            count_nxt_s     = count_inc_s;
        end else if (running_s) begin
            prescaler_nxt_s = prescaler_r + 18'd1;
        end else begin
            prescaler_nxt_s = prescaler_r;
        end
    end

    // State, prescaler, count, snapshot and overflow registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r     <= IDLE;
            prescaler_r <= 18'd0;
            count_r     <= 16'd0;
            snapshot_r  <= 16'd0;
            ovf_r       <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            prescaler_r <= prescaler_nxt_s;
            count_r     <= count_nxt_s;
            // Stop captures the post-edge value; latch captures the old value
            if (stop_s) begin
                snapshot_r <= count_inc_s;
            end else if (latch_s) begin
                snapshot_r <= count_r;
            end
            // A wrap beats a same-cycle clear so an overflow is never lost
            if (start_s) begin
                ovf_r <= 1'b0;
            end else if (wrap_s) begin
                ovf_r <= 1'b1;
            end else if (clr_s) begin
                ovf_r <= 1'b0;
            end
        end
    end

`ifdef STOPWATCH_IRQ_EN
    logic irq_en_r;
    logic irq_n_r;

    // Interrupt enable register and registered interrupt output
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            irq_en_r <= 1'b0;
            irq_n_r  <= 1'b1;
        end else begin
            if (wr_s && (reg_addr_i == 3'd6)) begin
                irq_en_r <= data_i[0];
            end
            irq_n_r <= !(ovf_r && irq_en_r);
        end
    end

    assign irq_en_s = irq_en_r;
    assign irq_n_o  = irq_n_r;
`else
    assign irq_en_s = 1'b0;
    assign irq_n_o  = 1'b1;
`endif

    // Read multiplexer; reads have no side effects
    always_comb begin
        rd_data_s = 8'h00;
        case (reg_addr_i)
            3'd0:    rd_data_s = {6'd0, ovf_r, running_s};
            3'd4:    rd_data_s = snapshot_r[7:0];
            3'd5:    rd_data_s = snapshot_r[15:8];
            3'd6:    rd_data_s = {7'd0, irq_en_s};
            default: rd_data_s = 8'h00;
        endcase
    end

    assign data_o = rd_data_s;

endmodule

// File: doc/stopwatch.md
# stopwatch

Elapsed-time measurement peripheral for the nano6502, sitting on the CPU register bus beside the countdown timer. The CPU starts it, stops it, and reads back elapsed centiseconds. Reads come from a snapshot register, so a 16-bit value is never torn across two 8-bit reads. It detects count wrap and can optionally raise an interrupt on it.

## Interface
- CLK_FRE, 25_175_000, system clock frequency in Hz.
- CS_DELAY, CLK_FRE/100, clock cycles per centisecond tick. Must be ≥ 2 and < 2^18.
- clk_i  in  1  system clock; all state updates on rising edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- R_W_n  in  1  bus direction: 1 = read, 0 = write.
- reg_addr_i  in  3  register select.
- data_i  in  8  write data.
- stopwatch_cs  in  1  chip select; asserted for one clock per bus access.
- data_o  out  8  read data, combinational from reg_addr_i.
- irq_n_o  out  1  interrupt request, active-low. Reset value 1.

## Operation
Register map (W = write-strobe action, R = read value):
- 00: R {6'd0, ovf, running}. W with any data clears ovf.
- 01: W start strobe. Sets count=0, prescaler=0, ovf=0, state RUNNING. Restarts if already running. R returns 0.
- 02: W stop strobe. State IDLE, count held, snapshot<=count. No effect on count if already IDLE. R returns 0.
- 03: W latch strobe. snapshot<=count, in any state. R returns 0.
- 04: R snapshot[7:0]. W ignored.
- 05: R snapshot[15:8]. W ignored.
- 06: R/W {7'd0, irq_en} (only with STOPWATCH_IRQ_EN). Otherwise R returns 0 and W is ignored.
- 07: R 0, W ignored.

Behaviour:
- A write acts in the cycle where stopwatch_cs && !R_W_n. Reads have no side effects.
- State machine has two states, IDLE (reset) and RUNNING.
  - IDLE → RUNNING on the start strobe.
  - RUNNING → IDLE on the stop strobe.
  - No other transitions.
- Prescaler is 18 bits and runs only in RUNNING.
  - If prescaler == CS_DELAY-1: prescaler<=0 and count<=count+1.
  - Otherwise prescaler increments.
- Count is 16 bits and wraps 0xFFFF→0x0000. The wrap sets sticky ovf; counting continues.
- Reset values: count, snapshot, prescaler, ovf, irq_en are 0; state IDLE; data_o = 0x00 (addr 00 is not 0 only when running or ovf); irq_n_o = 1.

## Timing
- Start write sampled at edge E0. Then running=1 after E0, count=1 after edge E0+CS_DELAY, and count=N after E0+N·CS_DELAY.
- Stop at edge Es freezes count at its pre-Es value plus any tick also occurring at Es. The snapshot takes the same post-edge value.
- Latch concurrent with a tick: snapshot captures the pre-increment count (old register value).
- Start and ovf-clear in the same cycle cannot occur (single address). A wrap tick in the same cycle as a reg-00 write: set wins, ovf=1.
- Stop or latch while a read of 04/05 is in progress: data_o reflects the new snapshot from the next cycle.
- Reset asserted mid-count: all state returns to reset values immediately, with no clock required.
- data_o has zero-cycle latency from reg_addr_i; snapshot and status are registered.

## Configuration
- STOPWATCH_IRQ_EN defined:
  - Register 06 implements irq_en.
  - irq_n_o = !(ovf && irq_en), registered, asserted the cycle after ovf sets.
  - irq_n_o is released one cycle after ovf is cleared or irq_en is written 0.
- Undefined: irq_n_o is tied to 1, register 06 reads 0, and no irq_en flop exists.

## Test plan
- Reset, then read addrs 00–07 → all 0x00. irq_n_o = 1.
- CS_DELAY=10: start, wait 250 cycles, stop, read 04/05 → 0x19/0x00. Status 0x00. Count is held after a further 100 cycles.
- CS_DELAY=10: start, latch after 35 cycles → snapshot 3. Running continues. Latch on the exact tick cycle returns the old value.
- Start while running at count 7 → count 0 and the prescaler restarts. The next tick comes CS_DELAY cycles later.
- CS_DELAY=2 (or force count 0xFFFE): run through the wrap → count 0x0000 and status 0x03. Write 00 → status 0x01.
- STOPWATCH_IRQ_EN: write 06=1, force a wrap → irq_n_o low the cycle after ovf sets. Write 00 → irq_n_o high. Rerun without the macro → irq_n_o stays 1.
